// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one load/store request, runs a req/ack handshake with
// memory and returns a single response pulse with extended load data or an error flag.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TMO_W   = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_err,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e            state_q, state_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              we_q, we_d;
   logic [2:0]        func3_q, func3_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [4:0]        rd_q, rd_d;
   logic [31:0]       data_q, data_d;
   logic              err_q, err_d;

   logic              illegal, misaligned;
   logic [31:0]       st_wdata;
   logic [3:0]        st_wstrb;

   function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                            input logic [1:0]  lane,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      unique case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      illegal    = (req_func3 == 3'b011) || (req_func3 == 3'b110) || (req_func3 == 3'b111) ||
                   (req_we && req_func3[2]);
      misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   // Store lanes are replicated so memory can pick any byte/half by strobe alone.
   always_comb begin
      st_wdata = req_wdata;
      st_wstrb = 4'b1111;
      case (req_func3[1:0])
         2'b00: begin
            st_wdata = {4{req_wdata[7:0]}};
            st_wstrb = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{req_wdata[15:0]}};
            st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
      if (!req_we) st_wstrb = 4'b0000;
   end

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      we_d    = we_q;
      func3_d = func3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rd_d    = rd_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d    = req_we;
               func3_d = req_func3;
               addr_d  = req_addr;
               wdata_d = st_wdata;
               wstrb_d = st_wstrb;
               rd_d    = req_rd;
               tmo_d   = '0;
               data_d  = 32'd0;
               if (illegal || misaligned) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end else begin
                  err_d   = 1'b0;
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            // An ack arriving on the final timeout cycle still completes normally.
            if (mem_ack) begin
               data_d  = we_q ? 32'd0 : load_ext(func3_q, addr_q[1:0], mem_rdata);
               err_d   = 1'b0;
               state_d = StResp;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               data_d  = 32'd0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         func3_q <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         rd_q    <= 5'd0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         func3_q <= func3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      req_ready  = (state_q == StIdle);
      busy       = (state_q != StIdle);
      mem_req    = (state_q == StReq);
      mem_we     = mem_req && we_q;
      mem_wstrb  = mem_req ? wstrb_q : 4'd0;
      mem_addr   = {addr_q[31:2], 2'b00};
      mem_wdata  = wdata_q;
      resp_valid = (state_q == StResp);
      resp_data  = resp_valid ? data_q : 32'd0;
      resp_err   = resp_valid && err_q;
      resp_rd    = (resp_valid && !we_q) ? rd_q : 5'd0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs change and outputs are sampled on the falling edge.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_func3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        resp_valid, resp_err, busy;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;

   int passes = 0;
   int total  = 0;
   int cnt;

   load_store_unit #(.TIMEOUT(64), .TMO_W(7)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_err(resp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
      req_valid = 1'b1;
      req_we    = we;
      req_func3 = f3;
      req_addr  = addr;
      req_wdata = wdata;
      req_rd    = rd;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Ack during the first request cycle and check the single response that follows.
   task automatic ack_once(input string tag, input logic [31:0] rdata, input logic [31:0] exp_data,
                           input logic [4:0] exp_rd);
      check({tag, "_memreq"}, 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0;
      check({tag, "_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_data"}, resp_data, exp_data);
      check({tag, "_rd"}, 32'(resp_rd), 32'(exp_rd));
      check({tag, "_err"}, 32'(resp_err), 32'd0);
      @(negedge clk);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_memreq", 32'(mem_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst_data", resp_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // LB, ack k=1
      issue(1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7);
      check("lb_addr", mem_addr, 32'h0000_0100);
      check("lb_wstrb", 32'(mem_wstrb), 32'd0);
      check("lb_busy", 32'(busy), 32'd1);
      check("lb_notready", 32'(req_ready), 32'd0);
      ack_once("lb", 32'h80FF_0000, 32'hFFFF_FF80, 5'd7);

      // LHU with ack on the fifth request cycle
      issue(1'b0, 3'b101, 32'h0000_0102, 32'd0, 5'd9);
      for (int i = 1; i <= 5; i++) begin
         check("lhu_memreq", 32'(mem_req), 32'd1);
         if (i == 5) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBEEF_1234;
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
      check("lhu_valid", 32'(resp_valid), 32'd1);
      check("lhu_data", resp_data, 32'h0000_BEEF);
      check("lhu_memreq_off", 32'(mem_req), 32'd0);
      @(negedge clk);

      issue(1'b0, 3'b001, 32'h0000_0102, 32'd0, 5'd3);
      ack_once("lh", 32'h8001_0000, 32'hFFFF_8001, 5'd3);
      issue(1'b0, 3'b100, 32'h0000_0101, 32'd0, 5'd4);
      ack_once("lbu", 32'h0000_9900, 32'h0000_0099, 5'd4);
      issue(1'b0, 3'b010, 32'h0000_0104, 32'd0, 5'd31);
      ack_once("lw", 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd31);

      // Stores
      issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 5'd5);
      check("sb_wstrb", 32'(mem_wstrb), 32'h2);
      check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      check("sb_addr", mem_addr, 32'h0000_0200);
      check("sb_we", 32'(mem_we), 32'd1);
      ack_once("sb", 32'h5555_5555, 32'd0, 5'd0);
      issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_56AB, 5'd5);
      check("sh_wstrb", 32'(mem_wstrb), 32'hC);
      check("sh_wdata", mem_wdata, 32'h56AB_56AB);
      ack_once("sh", 32'd0, 32'd0, 5'd0);
      issue(1'b1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 5'd5);
      check("sw_wstrb", 32'(mem_wstrb), 32'hF);
      check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      ack_once("sw", 32'd0, 32'd0, 5'd0);

      // Misaligned and illegal requests respond immediately with an error
      issue(1'b0, 3'b010, 32'h0000_0102, 32'd0, 5'd1);
      check("mis_memreq", 32'(mem_req), 32'd0);
      check("mis_valid", 32'(resp_valid), 32'd1);
      check("mis_err", 32'(resp_err), 32'd1);
      check("mis_data", resp_data, 32'd0);
      @(negedge clk);
      check("mis_ready", 32'(req_ready), 32'd1);
      issue(1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF, 5'd1);
      check("ill_memreq", 32'(mem_req), 32'd0);
      check("ill_valid", 32'(resp_valid), 32'd1);
      check("ill_err", 32'(resp_err), 32'd1);
      @(negedge clk);

      // Timeout with no ack
      issue(1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd2);
      cnt = 0;
      for (int i = 0; i < 100 && mem_req; i++) begin
         cnt++;
         @(negedge clk);
      end
      check("tmo_cycles", 32'(cnt), 32'd64);
      check("tmo_valid", 32'(resp_valid), 32'd1);
      check("tmo_err", 32'(resp_err), 32'd1);
      check("tmo_data", resp_data, 32'd0);
      @(negedge clk);

      // Ack on the last allowed cycle wins over the timeout
      issue(1'b0, 3'b010, 32'h0000_0404, 32'd0, 5'd2);
      cnt = 0;
      for (int i = 1; i <= 64; i++) begin
         if (mem_req) cnt++;
         if (i == 64) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h1357_9BDF;
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
      check("tmo64_cycles", 32'(cnt), 32'd64);
      check("tmo64_valid", 32'(resp_valid), 32'd1);
      check("tmo64_err", 32'(resp_err), 32'd0);
      check("tmo64_data", resp_data, 32'h1357_9BDF);
      @(negedge clk);

      // Reset while a request is outstanding; a late ack must be ignored
      issue(1'b0, 3'b010, 32'h0000_0500, 32'd0, 5'd6);
      check("rreq_memreq", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rreq_drop", 32'(mem_req), 32'd0);
      check("rreq_novalid", 32'(resp_valid), 32'd0);
      rst     = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("rreq_lateack_valid", 32'(resp_valid), 32'd0);
      check("rreq_lateack_memreq", 32'(mem_req), 32'd0);
      check("rreq_ready", 32'(req_ready), 32'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
